// File: rtl/fp8_sched_pkg.sv
// Shared types and constants for the fp8_sched round-robin front end to fp8_top.
package fp8_sched_pkg;

  typedef enum logic [1:0] {
    FP8S_IDLE  = 2'd0,
    FP8S_ISSUE = 2'd1,
    FP8S_WAIT  = 2'd2,
    FP8S_RESP  = 2'd3
  } fp8s_state_e;

  localparam logic [1:0] OP_ADD      = 2'b00;
  localparam logic [1:0] OP_SUB      = 2'b01;
  localparam logic [1:0] OP_MUL      = 2'b10;
  localparam logic [1:0] OP_RESERVED = 2'b11;

  // Bit positions inside the 4-bit {zero, overflow, underflow, inexact} flag word.
  localparam int FLAG_ZERO = 3;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_INX  = 0;

  localparam logic [7:0] RESULT_ABORT = 8'h00;
  localparam logic [3:0] FLAGS_ABORT  = 4'h0;

endpackage

// File: rtl/fp8_sched_rr_arb.sv
// Combinational round-robin picker: first requester after last_i, searching cyclically.
module fp8_rr_arb
  import fp8_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [IW:0] cand_w;

  // Walk the NUM_REQ candidates starting one past the previous owner; first hit wins.
  always_comb begin
    grant_o = {NUM_REQ{1'b0}};
    idx_o   = {IW{1'b0}};
    any_o   = 1'b0;
    cand_w  = {(IW+1){1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_w = {1'b0, last_i} + (IW+1)'(k);
      if (cand_w >= (IW+1)'(NUM_REQ)) begin
        cand_w = cand_w - (IW+1)'(NUM_REQ);
      end else begin
        cand_w = cand_w;
      end
      if (!any_o && req_i[cand_w[IW-1:0]]) begin
        any_o                    = 1'b1;
        grant_o[cand_w[IW-1:0]]  = 1'b1;
        idx_o                    = cand_w[IW-1:0];
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/fp8_sched.sv
// Round-robin scheduler sharing one fp8_top between NUM_REQ requesters, with a done watchdog.
// Optional completed-op counter on stat_ops is built when FP8_SCHED_STATS_EN is defined.
module fp8_sched
  import fp8_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  input  logic [2*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [7:0]             rsp_result,
  output logic [3:0]             rsp_flags,
  output logic                   rsp_err,
  output logic                   fu_start,
  output logic [7:0]             fu_a,
  output logic [7:0]             fu_b,
  output logic [1:0]             fu_op,
  input  logic                   fu_done,
  input  logic [7:0]             fu_result,
  input  logic [3:0]             fu_flags,
  output logic [15:0]            stat_ops
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  fp8s_state_e        state_q;
  logic [IW-1:0]      last_grant_q;
  logic [IW-1:0]      owner_q;
  logic               fu_start_q;
  logic [7:0]         fu_a_q;
  logic [7:0]         fu_b_q;
  logic [1:0]         fu_op_q;
  logic [TW-1:0]      timer_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [7:0]         rsp_result_q;
  logic [3:0]         rsp_flags_q;
  logic               rsp_err_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [7:0]         sel_a;
  logic [7:0]         sel_b;
  logic [1:0]         sel_op;
  logic [NUM_REQ-1:0] owner_onehot;
  logic               rsp_hs;

  fp8_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req_i   (req_valid),
    .last_i  (last_grant_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign sel_a        = req_a[{arb_idx, 3'b000} +: 8];
  assign sel_b        = req_b[{arb_idx, 3'b000} +: 8];
  assign sel_op       = req_op[{arb_idx, 1'b0} +: 2];
  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign rsp_hs       = (state_q == FP8S_RESP) && rsp_ready[owner_q];

  // Grants are only offered while idle, so at most one command is ever in flight.
  assign req_ready = (state_q == FP8S_IDLE) ? arb_grant : {NUM_REQ{1'b0}};

  // Scheduler FSM: accept, pulse start, wait for done or watchdog, hold response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FP8S_IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      owner_q      <= {IW{1'b0}};
      fu_start_q   <= 1'b0;
      fu_a_q       <= 8'h00;
      fu_b_q       <= 8'h00;
      fu_op_q      <= 2'b00;
      timer_q      <= {TW{1'b0}};
      rsp_valid_q  <= {NUM_REQ{1'b0}};
      rsp_result_q <= 8'h00;
      rsp_flags_q  <= 4'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        FP8S_IDLE: begin
          if (arb_any) begin
            fu_a_q     <= sel_a;
            fu_b_q     <= sel_b;
            fu_op_q    <= sel_op;
            owner_q    <= arb_idx;
            fu_start_q <= 1'b1;
            state_q    <= FP8S_ISSUE;
          end else begin
            state_q <= FP8S_IDLE;
          end
        end
        FP8S_ISSUE: begin
          fu_start_q <= 1'b0;
          timer_q    <= {TW{1'b0}};
          state_q    <= FP8S_WAIT;
        end
        FP8S_WAIT: begin
          // A done arriving on the timeout cycle still delivers the real result.
          if (fu_done) begin
            rsp_result_q <= fu_result;
            rsp_flags_q  <= fu_flags;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= owner_onehot;
            state_q      <= FP8S_RESP;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_result_q <= RESULT_ABORT;
            rsp_flags_q  <= FLAGS_ABORT;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= owner_onehot;
            state_q      <= FP8S_RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        FP8S_RESP: begin
          if (rsp_hs) begin
            rsp_valid_q  <= {NUM_REQ{1'b0}};
            last_grant_q <= owner_q;
            state_q      <= FP8S_IDLE;
          end else begin
            state_q <= FP8S_RESP;
          end
        end
        default: begin
          state_q <= FP8S_IDLE;
        end
      endcase
    end
  end

  assign fu_start   = fu_start_q;
  assign fu_a       = fu_a_q;
  assign fu_b       = fu_b_q;
  assign fu_op      = fu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

`ifdef FP8_SCHED_STATS_EN
  logic [15:0] stat_ops_q;

  // Counts every response handshake, watchdog aborts included; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops_q <= 16'h0000;
    end else if (rsp_hs) begin
      stat_ops_q <= stat_ops_q + 16'h0001;
    end else begin
      stat_ops_q <= stat_ops_q;
    end
  end

  assign stat_ops = stat_ops_q;
`else
  assign stat_ops = 16'h0000;
`endif

endmodule

// File: tb/tb_fp8_sched.sv
// Self-checking bench for fp8_sched with a behavioural fp8_top stub and round-robin reference model.
module tb_fp8_sched;

  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [8*NR-1:0] req_a;
  logic [8*NR-1:0] req_b;
  logic [2*NR-1:0] req_op;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready;
  logic [7:0]      rsp_result;
  logic [3:0]      rsp_flags;
  logic            rsp_err;
  logic            fu_start;
  logic [7:0]      fu_a;
  logic [7:0]      fu_b;
  logic [1:0]      fu_op;
  logic            fu_done;
  logic [7:0]      fu_result;
  logic [3:0]      fu_flags;
  logic [15:0]     stat_ops;

  int vectors    = 0;
  int miscompares = 0;
  int last_g;
  int stat_cnt;

  fp8_sched #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .fu_start   (fu_start),
    .fu_a       (fu_a),
    .fu_b       (fu_b),
    .fu_op      (fu_op),
    .fu_done    (fu_done),
    .fu_result  (fu_result),
    .fu_flags   (fu_flags),
    .stat_ops   (stat_ops)
  );

  always #5 clk = ~clk;

  // Stub fp8_top: the two real E4M3 cases from the plan, otherwise an arbitrary tag of the operands.
  function automatic logic [7:0] stub_res(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    if (op == 2'b00 && a == 8'h38 && b == 8'h38) return 8'h40;
    if (op == 2'b10 && a == 8'h40 && b == 8'h3C) return 8'h44;
    return (a ^ {b[3:0], b[7:4]}) + {6'b000000, op};
  endfunction

  function automatic logic [3:0] stub_flg(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    return a[3:0] ^ b[7:4] ^ {2'b00, op};
  endfunction

  function automatic int exp_grant(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_stat();
`ifdef FP8_SCHED_STATS_EN
    return 16'(stat_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_op[2*i +: 2] = op;
    req_valid[i]     = 1'b1;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rsp_ready = '0;
    fu_done   = 1'b0;
    reset_n   = 1'b0;
    #2;
    vectors++;
    if ({req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err, fu_start, fu_a, fu_b, fu_op, stat_ops} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rsp_valid=%b fu_start=%b fu_a=%h rsp_result=%h rsp_err=%b stat=%0d, required all zero",
               rsp_valid, fu_start, fu_a, rsp_result, rsp_err, stat_ops);
    end
    step();
    reset_n  = 1'b1;
    last_g   = NR - 1;
    stat_cnt = 0;
    step();
  endtask

  // One full transaction: grant, issue, done or watchdog, optional backpressure, handshake.
  task automatic serve_one(input int lat, input int bp, input bit respond, input int refill, output int obs_g);
    int g;
    logic [7:0] ea, eb, er;
    logic [1:0] eo;
    logic [3:0] ef, oh;
    logic eerr;
    #1;
    g = exp_grant(req_valid, last_g);
    obs_g = -1;
    for (int i = 0; i < NR; i++) if (req_ready[i]) obs_g = i;
    oh = 4'b0001 << g;
    vectors++;
    if (req_ready !== oh) begin
      miscompares++;
      $display("FAIL grant: req_ready=%b required %b", req_ready, oh);
    end
    ea = req_a[8*g +: 8];
    eb = req_b[8*g +: 8];
    eo = req_op[2*g +: 2];
    step();
    if (refill == 0) req_valid[g] = 1'b0;
    else if (refill == 2) set_req(g, 8'($urandom), 8'($urandom), 2'($urandom));
    vectors++;
    if ({fu_start, fu_a, fu_b, fu_op, req_ready} !== {1'b1, ea, eb, eo, 4'b0000}) begin
      miscompares++;
      $display("FAIL issue: start=%b a=%h b=%h op=%b ready=%b required 1 %h %h %b 0000",
               fu_start, fu_a, fu_b, fu_op, req_ready, ea, eb, eo);
    end
    step();
    vectors++;
    if ({fu_start, rsp_valid} !== 5'b00000) begin
      miscompares++;
      $display("FAIL start_pulse: fu_start=%b rsp_valid=%b required 0 0000", fu_start, rsp_valid);
    end
    if (respond) begin
      repeat (lat - 1) step();
      fu_done   = 1'b1;
      fu_result = stub_res(ea, eb, eo);
      fu_flags  = stub_flg(ea, eb, eo);
      er = fu_result; ef = fu_flags; eerr = 1'b0;
      step();
      fu_done   = 1'b0;
      fu_result = 8'($urandom);
      fu_flags  = 4'($urandom);
    end else begin
      repeat (TO - 1) step();
      vectors++;
      if (rsp_valid !== 4'b0000) begin
        miscompares++;
        $display("FAIL timeout_early: rsp_valid=%b required 0000 before %0d wait cycles", rsp_valid, TO);
      end
      step();
      er = 8'h00; ef = 4'h0; eerr = 1'b1;
    end
    for (int k = 0; k <= bp; k++) begin
      vectors++;
      if ({rsp_valid, rsp_result, rsp_flags, rsp_err, req_ready} !== {oh, er, ef, eerr, 4'b0000}) begin
        miscompares++;
        $display("FAIL response(hold %0d): valid=%b result=%h flags=%h err=%b ready=%b required %b %h %h %b 0000",
                 k, rsp_valid, rsp_result, rsp_flags, rsp_err, req_ready, oh, er, ef, eerr);
      end
      if (k < bp) begin
        rsp_ready = 4'($urandom) & ~oh;
        step();
      end
    end
    rsp_ready = oh | 4'($urandom);
    step();
    rsp_ready = '0;
    last_g = g;
    stat_cnt++;
    vectors++;
    if ({rsp_valid, stat_ops} !== {4'b0000, exp_stat()}) begin
      miscompares++;
      $display("FAIL after_handshake: rsp_valid=%b stat_ops=%0d required 0000 %0d", rsp_valid, stat_ops, exp_stat());
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_single();
    int g;
    apply_reset();
    set_req(0, 8'h38, 8'h38, 2'b00);
    serve_one(2, 0, 1'b1, 0, g);
    vectors++;
    if (g !== 0) begin
      miscompares++;
      $display("FAIL single_grant: granted %0d required 0", g);
    end
  endtask

  task automatic test_contention();
    int g;
    apply_reset();
    for (int i = 0; i < NR; i++) set_req(i, 8'h40, 8'h3C, 2'b10);
    for (int k = 0; k < 5; k++) begin
      serve_one(int'($urandom_range(1, 4)), 0, 1'b1, 1, g);
      vectors++;
      if (g !== k % NR) begin
        miscompares++;
        $display("FAIL contention_order: op %0d granted %0d required %0d", k, g, k % NR);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int g;
    set_req(1, 8'h3C, 8'h44, 2'b01);
    set_req(2, 8'h11, 8'h22, 2'b00);
    serve_one(3, 5, 1'b1, 0, g);
    serve_one(1, 2, 1'b1, 0, g);
  endtask

  task automatic test_timeout();
    int g;
    set_req(3, 8'h5A, 8'hA5, 2'b10);
    serve_one(1, 1, 1'b0, 0, g);
    step();
    step();
    fu_done = 1'b1;
    fu_result = 8'hAA;
    fu_flags = 4'hF;
    step();
    fu_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({rsp_valid, req_ready, fu_start} !== 9'b0) begin
        miscompares++;
        $display("FAIL late_done: rsp_valid=%b req_ready=%b fu_start=%b required zero", rsp_valid, req_ready, fu_start);
      end
      step();
    end
    set_req(0, 8'h22, 8'h33, 2'b01);
    serve_one(2, 0, 1'b1, 0, g);
  endtask

  task automatic test_reset_mid_wait();
    int g;
    apply_reset();
    set_req(1, 8'h77, 8'h66, 2'b10);
    step();
    req_valid = '0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err, fu_start, fu_a, fu_b, fu_op, stat_ops} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: fu_a=%h fu_b=%h fu_op=%b rsp_valid=%b, required all zero", fu_a, fu_b, fu_op, rsp_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    last_g = NR - 1;
    stat_cnt = 0;
    step();
    fu_done = 1'b1;
    step();
    fu_done = 1'b0;
    vectors++;
    if ({rsp_valid, fu_start} !== 5'b0) begin
      miscompares++;
      $display("FAIL orphan_done: rsp_valid=%b fu_start=%b required zero", rsp_valid, fu_start);
    end
    set_req(0, 8'h01, 8'h02, 2'b00);
    set_req(2, 8'h03, 8'h04, 2'b01);
    serve_one(1, 0, 1'b1, 0, g);
    vectors++;
    if (g !== 0) begin
      miscompares++;
      $display("FAIL post_reset_grant: granted %0d required 0", g);
    end
    serve_one(1, 0, 1'b1, 0, g);
    vectors++;
    if (g !== 2) begin
      miscompares++;
      $display("FAIL second_grant: granted %0d required 2", g);
    end
  endtask

  task automatic test_stats();
    int g;
    apply_reset();
    set_req(2, 8'h10, 8'h20, 2'b00);
    serve_one(2, 0, 1'b1, 0, g);
    set_req(1, 8'h30, 8'h40, 2'b10);
    serve_one(1, 0, 1'b0, 0, g);
    set_req(3, 8'h50, 8'h60, 2'b01);
    serve_one(4, 1, 1'b1, 0, g);
    vectors++;
`ifdef FP8_SCHED_STATS_EN
    if (stat_ops !== 16'd3) begin
      miscompares++;
      $display("FAIL stat_count: stat_ops=%0d required 3", stat_ops);
    end
`else
    if (stat_ops !== 16'd0) begin
      miscompares++;
      $display("FAIL stat_tied: stat_ops=%0d required 0", stat_ops);
    end
`endif
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, 8'($urandom), 8'($urandom), 2'($urandom));
      end
      if (req_valid == '0) set_req(int'($urandom_range(0, NR - 1)), 8'($urandom), 8'($urandom), 2'($urandom));
      serve_one(int'($urandom_range(1, 12)), int'($urandom_range(0, 3)), $urandom_range(0, 7) != 0,
                int'($urandom_range(0, 2)), g);
    end
    req_valid = '0;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = '0;
    fu_done   = 1'b0;
    fu_result = 8'h00;
    fu_flags  = 4'h0;
    last_g    = NR - 1;
    stat_cnt  = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_stats();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
